odd_seq_monitor: RTL

- Downstream checker for the odd-number counter stream. Samples an 8-bit count each cycle its valid is high.
- Verifies that every sample is odd and exactly 2 above the previous sample, modulo 2^WIDTH.
- Declares lock after LOCK_CNT consecutive good samples. Flags and counts sequence errors while locked.
- Sits in the counter subsystem between the odd counter output and status/debug logic.

---
 rtl/odd_seq_monitor.sv | 115 +++++++++++
 1 files changed

// File: rtl/odd_seq_monitor.sv
// Checks an odd-counter stream: each valid sample must be odd and exactly +2 (mod 2^WIDTH)
// from the previous one. Locks after LOCK_CNT good samples; counts errors seen while locked.
module odd_seq_monitor #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             valid_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] last_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } state_t;

  state_t           state, state_n;
  logic [GW-1:0]    good_cnt, good_cnt_n;
  logic [GW:0]      good_inc;
  logic [WIDTH-1:0] prev, expected;
  logic [ERR_W-1:0] err_cnt, err_cnt_n;
  logic             err, err_n;
  logic             odd, good;

  assign expected = prev + WIDTH'(2);
  assign odd      = valid_i & cnt_i[0];
  assign good     = odd & (cnt_i == expected);
  assign good_inc = {1'b0, good_cnt} + (GW+1)'(1);

  always_comb begin
    state_n    = state;
    good_cnt_n = good_cnt;
    err_cnt_n  = err_cnt;
    err_n      = 1'b0;
    if (valid_i) begin
      unique case (state)
        IDLE: begin
          if (odd) begin
            if (LOCK_CNT == 1) begin
              state_n    = LOCKED;
              good_cnt_n = '0;
            end else begin
              state_n    = ACQ;
              good_cnt_n = GW'(1);
            end
          end
        end
        ACQ: begin
          if (good) begin
            if (good_inc >= (GW+1)'(LOCK_CNT)) begin
              state_n    = LOCKED;
              good_cnt_n = '0;
            end else begin
              good_cnt_n = good_inc[GW-1:0];
            end
          end else if (odd) begin
            // odd but off-sequence: this sample becomes the new reference
            good_cnt_n = GW'(1);
          end else begin
            state_n    = IDLE;
            good_cnt_n = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            err_n = 1'b1;
            if (err_cnt != '1) err_cnt_n = err_cnt + ERR_W'(1);
            if (odd) begin
              state_n    = ACQ;
              good_cnt_n = GW'(1);
            end else begin
              state_n    = IDLE;
              good_cnt_n = '0;
            end
          end
        end
        default: begin
          state_n    = IDLE;
          good_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      good_cnt <= '0;
      prev     <= '0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      good_cnt <= good_cnt_n;
      err      <= err_n;
      err_cnt  <= err_cnt_n;
      if (valid_i) prev <= cnt_i;
    end
  end

  assign locked_o  = (state == LOCKED);
  assign err_o     = err;
  assign err_cnt_o = err_cnt;
  assign last_o    = prev;

endmodule
